// File: rtl/br_perf_monitor_pkg.sv
// Shared types and helpers for the branch-prediction performance monitor.
package br_perf_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   localparam logic [1:0] RD_SEL_BR    = 2'd0;
   localparam logic [1:0] RD_SEL_MISS  = 2'd1;
   localparam logic [1:0] RD_SEL_CYC   = 2'd2;
   localparam logic [1:0] RD_SEL_TRACE = 2'd3;

   // Increment that sticks at the all-ones value of a w-bit counter (w <= 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
      logic [31:0] max_v;
      max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
      return (v >= max_v) ? max_v : v + 32'd1;
   endfunction

endpackage

// File: rtl/br_perf_monitor_if.sv
// Snapshot read port: request (channel/select) in, registered data/valid out.
interface br_perf_monitor_if #(
   parameter int NUM_CH = 2,
   parameter int CNT_W  = 16
);
   localparam int CH_W = $clog2(NUM_CH) + 1;

   logic             rd_en;
   logic [CH_W-1:0]  rd_ch;
   logic [1:0]       rd_sel;
   logic             rd_vld;
   logic [CNT_W-1:0] rd_data;

   modport master (output rd_en, rd_ch, rd_sel, input rd_vld, rd_data);
   modport slave  (input rd_en, rd_ch, rd_sel, output rd_vld, rd_data);

endinterface

// File: rtl/br_perf_monitor_chan.sv
// One predictor channel: saturating live branch/miss counters, snapshot copy
// and sticky overflow flag.
module br_perf_chan
   import br_perf_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             cnt_en_i,
   input  logic             live_clr_i,
   input  logic             snap_en_i,
   input  logic             br_instr_i,
   input  logic             br_miss_i,
   output logic [CNT_W-1:0] snap_br_o,
   output logic [CNT_W-1:0] snap_miss_o,
   output logic             ovf_o
);

   logic [CNT_W-1:0] r_br, r_miss;
   logic [CNT_W-1:0] w_br_nxt, w_miss_nxt;
   logic             w_br_inc, w_miss_inc, w_sat_hit;

   assign w_br_inc   = cnt_en_i & br_instr_i;
   assign w_miss_inc = w_br_inc & br_miss_i;
   assign w_br_nxt   = w_br_inc   ? CNT_W'(sat_inc(32'(r_br), CNT_W))   : r_br;
   assign w_miss_nxt = w_miss_inc ? CNT_W'(sat_inc(32'(r_miss), CNT_W)) : r_miss;
   assign w_sat_hit  = (w_br_inc & (&r_br)) | (w_miss_inc & (&r_miss));

   // Snapshot takes the post-increment value so the closing cycle is included.
   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_br        <= '0;
         r_miss      <= '0;
         snap_br_o   <= '0;
         snap_miss_o <= '0;
         ovf_o       <= 1'b0;
      end else begin
         r_br   <= live_clr_i ? '0 : w_br_nxt;
         r_miss <= live_clr_i ? '0 : w_miss_nxt;
         if (snap_en_i) begin
            snap_br_o   <= w_br_nxt;
            snap_miss_o <= w_miss_nxt;
         end
         if (w_sat_hit) ovf_o <= 1'b1;
      end
   end

endmodule

// File: rtl/br_perf_monitor.sv
// Branch-prediction performance monitor top: run/halt FSM, cycle counter,
// per-channel counters and registered snapshot read port.
// Optional mispredict PC trace buffer: define BR_PERF_MISS_TRACE_EN.
//
//   state   | meaning
//   IDLE    | cleared, not counting
//   RUN     | counting; window boundary or stop takes a snapshot
//   HALT    | stopped, live counters held, snapshot readable
module br_perf_monitor
   import br_perf_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int CNT_W       = 16,
   parameter int WINDOW      = 0,
   parameter int TRACE_DEPTH = 8
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              stop_i,
   input  logic              clr_i,
   input  logic [NUM_CH-1:0] br_instr_i,
   input  logic [NUM_CH-1:0] br_miss_i,
   input  logic [31:0]       br_pc_i,
   br_perf_monitor_if.slave  rd_if,
   output logic              win_done_o,
   output logic [NUM_CH-1:0] ovf_o,
   output logic [1:0]        state_o
);

   state_e           r_state;
   logic             r_win_done;
   logic [CNT_W-1:0] r_cyc, r_snap_cyc, w_cyc_nxt;
   logic             r_rd_vld;
   logic [CNT_W-1:0] r_rd_data, w_rd_val;
   logic             w_cnt_en, w_wrap, w_snap, w_live_clr;
   logic [CNT_W-1:0] w_snap_br   [NUM_CH];
   logic [CNT_W-1:0] w_snap_miss [NUM_CH];

   assign w_cnt_en   = (r_state == ST_RUN) & ~clr_i;
   assign w_wrap     = (WINDOW != 0) && w_cnt_en && (r_cyc == CNT_W'(WINDOW - 1));
   assign w_snap     = w_cnt_en & (w_wrap | stop_i);
   assign w_live_clr = w_wrap | ((r_state == ST_HALT) & start_i & ~clr_i);
   assign w_cyc_nxt  = w_cnt_en ? CNT_W'(sat_inc(32'(r_cyc), CNT_W)) : r_cyc;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state    <= ST_IDLE;
         r_win_done <= 1'b0;
      end else begin
         r_win_done <= w_snap;
         if (clr_i) r_state <= ST_IDLE;
         else begin
            case (r_state)
               ST_IDLE: if (start_i) r_state <= ST_RUN;
               ST_RUN:  if (stop_i)  r_state <= ST_HALT;
               ST_HALT: if (start_i) r_state <= ST_RUN;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_cyc      <= '0;
         r_snap_cyc <= '0;
      end else begin
         r_cyc <= w_live_clr ? '0 : w_cyc_nxt;
         if (w_snap) r_snap_cyc <= w_cyc_nxt;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
      br_perf_chan #(.CNT_W(CNT_W)) u_chan (
         .clk_i       (clk_i),
         .rst_i       (rst_i),
         .clr_i       (clr_i),
         .cnt_en_i    (w_cnt_en),
         .live_clr_i  (w_live_clr),
         .snap_en_i   (w_snap),
         .br_instr_i  (br_instr_i[g]),
         .br_miss_i   (br_miss_i[g]),
         .snap_br_o   (w_snap_br[g]),
         .snap_miss_o (w_snap_miss[g]),
         .ovf_o       (ovf_o[g])
      );
   end

`ifdef BR_PERF_MISS_TRACE_EN
   localparam int TP_W = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;

   logic [31:0]      r_trace [TRACE_DEPTH];
   logic [TP_W-1:0]  r_wptr, w_oldest, w_rd_addr;
   logic [TP_W:0]    r_trace_cnt;
   logic             w_trace_wr, w_trace_full;
   logic [CNT_W-1:0] w_trace_val;

   assign w_trace_wr   = w_cnt_en & br_instr_i[0] & br_miss_i[0];
   assign w_trace_full = (r_trace_cnt == (TP_W+1)'(TRACE_DEPTH));
   assign w_oldest     = w_trace_full ? r_wptr : '0;
   assign w_rd_addr    = TP_W'((int'(w_oldest) + int'(rd_if.rd_ch) % TRACE_DEPTH) % TRACE_DEPTH);
   // Entries beyond the fill level read as zero, so a cleared buffer is empty.
   assign w_trace_val  = ((TP_W+1)'(int'(rd_if.rd_ch) % TRACE_DEPTH) < r_trace_cnt) ?
                         CNT_W'(r_trace[w_rd_addr]) : '0;

   always_ff @(posedge clk_i) begin
      if (w_trace_wr && !rst_i) r_trace[r_wptr] <= br_pc_i;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         r_wptr      <= '0;
         r_trace_cnt <= '0;
      end else if (w_trace_wr) begin
         r_wptr <= (r_wptr == TP_W'(TRACE_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
         if (!w_trace_full) r_trace_cnt <= r_trace_cnt + 1'b1;
      end
   end
`else
   localparam int UNUSED_TRACE_DEPTH = TRACE_DEPTH;
   logic w_unused_pc;
   assign w_unused_pc = ^br_pc_i;
`endif

   always_comb begin
      w_rd_val = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (int'(rd_if.rd_ch) == c) begin
            case (rd_if.rd_sel)
               RD_SEL_BR:   w_rd_val = w_snap_br[c];
               RD_SEL_MISS: w_rd_val = w_snap_miss[c];
               RD_SEL_CYC:  w_rd_val = r_snap_cyc;
               default:     w_rd_val = '0;
            endcase
         end
      end
`ifdef BR_PERF_MISS_TRACE_EN
      if (rd_if.rd_sel == RD_SEL_TRACE) w_rd_val = w_trace_val;
`endif
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_rd_vld  <= 1'b0;
         r_rd_data <= '0;
      end else begin
         r_rd_vld <= rd_if.rd_en;
         if (rd_if.rd_en) r_rd_data <= w_rd_val;
      end
   end

   assign rd_if.rd_vld  = r_rd_vld;
   assign rd_if.rd_data = r_rd_data;
   assign win_done_o    = r_win_done;
   assign state_o       = r_state;

endmodule
